// File: rtl/wfg_stim_ramp_pkg.sv
// Shared types and constants for the sawtooth/triangle ramp stimulus generator.
package wfg_stim_ramp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_UP    = 2'd1,
    ST_DOWN  = 2'd2,
    ST_DRAIN = 2'd3
  } state_e;

  localparam logic MODE_SAW = 1'b0;
  localparam logic MODE_TRI = 1'b1;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/wfg_stim_ramp_step.sv
// Combinational next-sample calculator: saturating width+1 arithmetic,
// direction turn detection and the tlast flag that travels with the next sample.
module wfg_stim_ramp_step
  import wfg_stim_ramp_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         mode_i,
  input  logic         dir_i,
  input  logic [W-1:0] cur_i,
  input  logic [W-1:0] inc_i,
  input  logic [W-1:0] start_i,
  input  logic [W-1:0] end_i,
  output logic [W-1:0] next_o,
  output logic         turn_o,
  output logic         last_o
);

  logic [W:0]   sum_s;
  logic [W:0]   diff_s;
  logic [W:0]   look_s;
  logic [W-1:0] saw_next_s;
  logic [W-1:0] up_next_s;
  logic [W-1:0] dn_next_s;
  logic         degen_s;

  assign sum_s      = {1'b0, cur_i} + {1'b0, inc_i};
  assign diff_s     = {1'b0, cur_i} - {1'b0, inc_i};
  assign degen_s    = (inc_i == {W{1'b0}}) || (end_i <= start_i);
  assign saw_next_s = (sum_s > {1'b0, end_i}) ? start_i : sum_s[W-1:0];
  assign up_next_s  = (sum_s > {1'b0, end_i}) ? end_i : sum_s[W-1:0];
  assign dn_next_s  = (diff_s[W] || (diff_s[W-1:0] < start_i)) ? start_i : diff_s[W-1:0];
  // Sawtooth tlast belongs to the sample whose own successor wraps.
  assign look_s     = {1'b0, saw_next_s} + {1'b0, inc_i};

  // Select next sample, turn and tlast by mode and direction.
  always_comb begin
    next_o = cur_i;
    turn_o = 1'b0;
    last_o = 1'b0;
    if (degen_s) begin
      next_o = start_i;
      last_o = 1'b1;
    end else if (mode_i == MODE_SAW) begin
      next_o = saw_next_s;
      last_o = (look_s > {1'b0, end_i});
    end else if (dir_i == DIR_UP) begin
      if (cur_i == end_i) begin
        next_o = dn_next_s;
        turn_o = 1'b1;
        last_o = (dn_next_s == start_i);
      end else begin
        next_o = up_next_s;
        last_o = 1'b0;
      end
    end else begin
      if (cur_i == start_i) begin
        next_o = up_next_s;
        turn_o = 1'b1;
        last_o = 1'b0;
      end else begin
        next_o = dn_next_s;
        last_o = (dn_next_s == start_i);
      end
    end
  end

endmodule

// File: rtl/wfg_stim_ramp.sv
// Ramp stimulus generator: shadows config on enable and streams sawtooth or
// triangle samples on an AXI-Stream master with registered data/last/valid.
module wfg_stim_ramp
  import wfg_stim_ramp_pkg::*;
#(
  parameter int AXIS_DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ctrl_en_q_i,
  input  logic                       ctrl_mode_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_start_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_inc_q_i,
  input  logic [AXIS_DATA_WIDTH-1:0] cfg_end_q_i,
  input  logic                       wfg_axis_tready_i,
  output logic                       wfg_axis_tvalid_o,
  output logic [AXIS_DATA_WIDTH-1:0] wfg_axis_tdata_o,
  output logic                       wfg_axis_tlast_o,
  output logic                       active_o
);

  localparam int W = AXIS_DATA_WIDTH;

  state_e       state_q, state_d;
  logic         valid_q, valid_d;
  logic         last_q, last_d;
  logic         active_q, active_d;
  logic         mode_q, mode_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] start_q, start_d;
  logic [W-1:0] inc_q, inc_d;
  logic [W-1:0] end_q, end_d;

  logic         hs_s;
  logic [W-1:0] step_next_s;
  logic         step_turn_s;
  logic         step_last_s;
  logic [W:0]   cfg_sum_s;
  logic         cfg_degen_s;
  logic         first_last_s;

  assign hs_s         = valid_q & wfg_axis_tready_i;
  assign cfg_sum_s    = {1'b0, cfg_start_q_i} + {1'b0, cfg_inc_q_i};
  assign cfg_degen_s  = (cfg_inc_q_i == {W{1'b0}}) || (cfg_end_q_i <= cfg_start_q_i);
  // The very first sample is always start; only sawtooth can wrap straight after it.
  assign first_last_s = cfg_degen_s ||
                        ((ctrl_mode_q_i == MODE_SAW) && (cfg_sum_s > {1'b0, cfg_end_q_i}));

  wfg_stim_ramp_step #(.W(W)) u_step (
    .mode_i  (mode_q),
    .dir_i   ((state_q == ST_DOWN) ? DIR_DOWN : DIR_UP),
    .cur_i   (data_q),
    .inc_i   (inc_q),
    .start_i (start_q),
    .end_i   (end_q),
    .next_o  (step_next_s),
    .turn_o  (step_turn_s),
    .last_o  (step_last_s)
  );

  // Next-state and output-register logic.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    mode_d  = mode_q;
    start_d = start_q;
    inc_d   = inc_q;
    end_d   = end_q;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_en_q_i) begin
          start_d = cfg_start_q_i;
          inc_d   = cfg_inc_q_i;
          end_d   = cfg_end_q_i;
          mode_d  = ctrl_mode_q_i;
          data_d  = cfg_start_q_i;
          last_d  = first_last_s;
          valid_d = 1'b1;
          state_d = ST_UP;
        end else begin
          valid_d = 1'b0;
        end
      end
      ST_UP, ST_DOWN: begin
        if (!ctrl_en_q_i) begin
          if (valid_q && !wfg_axis_tready_i) begin
            state_d = ST_DRAIN;
          end else begin
            valid_d = 1'b0;
            state_d = ST_IDLE;
          end
        end else if (hs_s) begin
          data_d = step_next_s;
          last_d = step_last_s;
          if (step_turn_s) begin
            state_d = (state_q == ST_UP) ? ST_DOWN : ST_UP;
          end else begin
            state_d = state_q;
          end
        end else begin
          state_d = state_q;
        end
      end
      ST_DRAIN: begin
        if (hs_s) begin
          valid_d = 1'b0;
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
    active_d = (state_d != ST_IDLE);
  end

  // State, shadow config and AXI output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      valid_q  <= 1'b0;
      data_q   <= {W{1'b0}};
      last_q   <= 1'b0;
      active_q <= 1'b0;
      mode_q   <= MODE_SAW;
      start_q  <= {W{1'b0}};
      inc_q    <= {W{1'b0}};
      end_q    <= {W{1'b0}};
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      last_q   <= last_d;
      active_q <= active_d;
      mode_q   <= mode_d;
      start_q  <= start_d;
      inc_q    <= inc_d;
      end_q    <= end_d;
    end
  end

  assign wfg_axis_tvalid_o = valid_q;
  assign wfg_axis_tdata_o  = data_q;
  assign wfg_axis_tlast_o  = last_q;
  assign active_o          = active_q;

endmodule

// File: tb/tb_wfg_stim_ramp.sv
// Directed self-checking bench for wfg_stim_ramp with hand-computed sample sequences.
module tb_wfg_stim_ramp;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        mode;
  logic [31:0] cfg_start;
  logic [31:0] cfg_inc;
  logic [31:0] cfg_end;
  logic        tready;
  logic        tvalid;
  logic [31:0] tdata;
  logic        tlast;
  logic        active;

  int total;
  int bad;

  logic [31:0] ed[$];
  logic        el[$];

  wfg_stim_ramp #(.AXIS_DATA_WIDTH(32)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_en_q_i       (en),
    .ctrl_mode_q_i     (mode),
    .cfg_start_q_i     (cfg_start),
    .cfg_inc_q_i       (cfg_inc),
    .cfg_end_q_i       (cfg_end),
    .wfg_axis_tready_i (tready),
    .wfg_axis_tvalid_o (tvalid),
    .wfg_axis_tdata_o  (tdata),
    .wfg_axis_tlast_o  (tlast),
    .active_o          (active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enable(input logic m, input logic [31:0] s, input logic [31:0] i, input logic [31:0] e);
    mode = m; cfg_start = s; cfg_inc = i; cfg_end = e;
    en = 1'b1; tready = 1'b1;
    tick();
  endtask

  // Checks the currently presented beat against ed/el, advancing one cycle between beats.
  task automatic run_exp(input string tag);
    for (int k = 0; k < ed.size(); k++) begin
      if (k > 0) tick();
      check_val({tag, "_valid"}, {31'd0, tvalid}, 32'd1);
      check_val({tag, "_data"}, tdata, ed[k]);
      check_val({tag, "_last"}, {31'd0, tlast}, {31'd0, el[k]});
    end
  endtask

  task automatic disable_run(input string tag);
    en = 1'b0; tready = 1'b1;
    tick();
    check_val({tag, "_off_valid"}, {31'd0, tvalid}, 32'd0);
    check_val({tag, "_off_active"}, {31'd0, active}, 32'd0);
  endtask

  initial begin
    logic [31:0] tri_v [6];
    logic [31:0] prev_d;
    logic        prev_l;
    logic        prev_v;
    logic        rdy;
    int          beats;
    total = 0; bad = 0;
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; tready = 1'b0;
    cfg_start = 32'd0; cfg_inc = 32'd0; cfg_end = 32'd0;
    tri_v[0] = 32'd0; tri_v[1] = 32'd2; tri_v[2] = 32'd4;
    tri_v[3] = 32'd5; tri_v[4] = 32'd3; tri_v[5] = 32'd1;
    tick(); tick();
    check_val("rst_valid", {31'd0, tvalid}, 32'd0);
    check_val("rst_data", tdata, 32'd0);
    check_val("rst_last", {31'd0, tlast}, 32'd0);
    check_val("rst_active", {31'd0, active}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Sawtooth 0..3; first beat appears one cycle after enable.
    enable(1'b0, 32'd0, 32'd1, 32'd3);
    check_val("saw_active", {31'd0, active}, 32'd1);
    ed = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0, 32'd1};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_exp("saw");
    disable_run("saw");

    enable(1'b0, 32'd10, 32'd4, 32'd20);
    ed = '{32'd10, 32'd14, 32'd18, 32'd10, 32'd14};
    el = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_exp("saw_na");
    disable_run("saw_na");

    enable(1'b0, 32'hFFFF_FFF0, 32'h10, 32'hFFFF_FFFF);
    ed = '{32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_FFF0};
    el = '{1'b1, 1'b1, 1'b1};
    run_exp("saw_carry");
    disable_run("saw_carry");

    enable(1'b1, 32'd0, 32'd2, 32'd5);
    ed = '{32'd0, 32'd2, 32'd4, 32'd5, 32'd3, 32'd1, 32'd0, 32'd2, 32'd4};
    el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    run_exp("tri");
    disable_run("tri");

    // Triangle under ~30% tready: accepted beats follow the free-running sequence.
    mode = 1'b1; cfg_start = 32'd0; cfg_inc = 32'd2; cfg_end = 32'd5;
    en = 1'b1; tready = 1'b0;
    tick();
    beats = 0;
    for (int c = 0; c < 400 && beats < 14; c++) begin
      prev_d = tdata; prev_l = tlast; prev_v = tvalid;
      rdy = ($urandom_range(0, 9) < 3);
      tready = rdy;
      tick();
      if (prev_v && rdy) begin
        check_val("bp_data", prev_d, tri_v[beats % 6]);
        check_val("bp_last", {31'd0, prev_l}, {31'd0, ((beats % 6) == 0) && (beats > 0)});
        beats++;
      end else if (prev_v) begin
        check_val("bp_hold_valid", {31'd0, tvalid}, 32'd1);
        check_val("bp_hold_data", tdata, prev_d);
        check_val("bp_hold_last", {31'd0, tlast}, {31'd0, prev_l});
      end else begin
        check_val("bp_valid_lost", {31'd0, prev_v}, 32'd1);
      end
    end
    check_val("bp_beats", beats, 32'd14);
    disable_run("bp");

    // cfg_end change while running is ignored; then disable under stall drains.
    enable(1'b0, 32'd0, 32'd1, 32'd3);
    cfg_end = 32'd100;
    ed = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd0};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_exp("cfg_hold");
    en = 1'b0; tready = 1'b0;
    tick();
    check_val("drain_valid", {31'd0, tvalid}, 32'd1);
    check_val("drain_data", tdata, 32'd0);
    check_val("drain_active", {31'd0, active}, 32'd1);
    en = 1'b1;
    tick();
    check_val("drain_reen_valid", {31'd0, tvalid}, 32'd1);
    check_val("drain_reen_data", tdata, 32'd0);
    tready = 1'b1;
    tick();
    check_val("drain_done_valid", {31'd0, tvalid}, 32'd0);
    check_val("drain_done_active", {31'd0, active}, 32'd0);
    tick();
    ed = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    el = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    run_exp("new_cfg");
    disable_run("new_cfg");

    enable(1'b0, 32'd7, 32'd0, 32'd20);
    ed = '{32'd7, 32'd7, 32'd7};
    el = '{1'b1, 1'b1, 1'b1};
    run_exp("degen_inc0");
    disable_run("degen_inc0");

    enable(1'b1, 32'd7, 32'd1, 32'd7);
    run_exp("degen_eq");
    disable_run("degen_eq");

    // Asynchronous reset mid-stream, then restart from the new start.
    enable(1'b0, 32'd0, 32'd1, 32'd3);
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_valid", {31'd0, tvalid}, 32'd0);
    check_val("arst_data", tdata, 32'd0);
    check_val("arst_last", {31'd0, tlast}, 32'd0);
    check_val("arst_active", {31'd0, active}, 32'd0);
    en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    enable(1'b0, 32'd5, 32'd1, 32'd8);
    ed = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd5};
    el = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    run_exp("restart");
    disable_run("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
